// File: rtl/grid_collision_check_if.sv
// Request, grid-RAM read and result signals of grid_collision_check.
// The slave modport is the checker's view; the master modport is the surrounding logic's view.
interface grid_collision_check_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              chk_valid;
    logic              chk_ready;
    logic [DATA_W-1:0] activeGrid1;
    logic [DATA_W-1:0] activeGrid2;
    logic [ADDR_W-1:0] activeAddr1;
    logic [ADDR_W-1:0] activeAddr2;
    logic [ADDR_W-1:0] activeAddr3;
    logic [ADDR_W-1:0] activeAddr4;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              res_valid;
    logic              res_ready;
    logic              res_hit;
    logic [3:0]        res_hitMask;
    logic              clr_cnt;
    logic [15:0]       hit_cnt;

    modport slave (
        input  chk_valid, activeGrid1, activeGrid2,
               activeAddr1, activeAddr2, activeAddr3, activeAddr4,
               mem_rdata, res_ready, clr_cnt,
        output chk_ready, mem_en, mem_addr, res_valid, res_hit, res_hitMask, hit_cnt
    );

    modport master (
        output chk_valid, activeGrid1, activeGrid2,
               activeAddr1, activeAddr2, activeAddr3, activeAddr4,
               mem_rdata, res_ready, clr_cnt,
        input  chk_ready, mem_en, mem_addr, res_valid, res_hit, res_hitMask, hit_cnt
    );
endinterface

// File: rtl/grid_collision_check.sv
// Checks four grid RAM words against an X-cell mask and reports per-word hits.
// The latency is fixed at 5 edges. A saturating 16-bit counter counts accepted hit results.
module grid_collision_check #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input logic                  CLK,
    input logic                  RST_n,
    grid_collision_check_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                      r_state;
    logic [DATA_W-1:0]           r_mask;
    logic [3:0][ADDR_W-1:0]      r_addr;
    logic [1:0]                  r_cnt;
    logic                        r_chk_ready;
    logic                        r_mem_en;
    logic [ADDR_W-1:0]           r_mem_addr;
    logic                        r_res_valid;
    logic                        r_res_hit;
    logic [3:0]                  r_hit_mask;
    logic [15:0]                 r_hit_cnt;
    logic                        w_word_hit;

    assign w_word_hit = |(bus.mem_rdata & r_mask);

    assign bus.chk_ready   = r_chk_ready;
    assign bus.mem_en      = r_mem_en;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_hit     = r_res_hit;
    assign bus.res_hitMask = r_hit_mask;
    assign bus.hit_cnt     = r_hit_cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_chk_ready <= 1'b1;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_hit_mask  <= '0;
            r_hit_cnt   <= '0;
        end else begin
            // Clear takes priority over a coincident result handshake.
            if (bus.clr_cnt) begin
                r_hit_cnt <= '0;
            end else if (r_state == DONE && bus.res_ready && r_res_hit && r_hit_cnt != '1) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.chk_valid) begin
                        r_mask      <= bus.activeGrid1 | bus.activeGrid2;
                        r_addr      <= {bus.activeAddr4, bus.activeAddr3,
                                        bus.activeAddr2, bus.activeAddr1};
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= bus.activeAddr1;
                        r_cnt       <= '0;
                        r_hit_mask  <= '0;
                        r_res_hit   <= 1'b0;
                        r_chk_ready <= 1'b0;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    // Data for the read issued r_cnt-1 edges ago arrives now.
                    if (r_cnt != 2'd0) begin
                        r_hit_mask[r_cnt - 2'd1] <= w_word_hit;
                    end
                    if (r_cnt == 2'd3) begin
                        r_mem_en <= 1'b0;
                        r_state  <= DRAIN;
                    end else begin
                        r_mem_addr <= r_addr[r_cnt + 2'd1];
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                DRAIN: begin
                    r_hit_mask[3] <= w_word_hit;
                    r_res_hit     <= (|r_hit_mask[2:0]) | w_word_hit;
                    r_res_valid   <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_chk_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grid_collision_check.sv
// Randomised and directed checks of grid_collision_check.
// A behavioural RAM supplies read data, and a reference model computes hit flags and the counter.
module tb_grid_collision_check;
    localparam int AW = 11;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RST_n;
    always #5 CLK = ~CLK;

    grid_collision_check_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    grid_collision_check #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    logic [DW-1:0] ram [2**AW];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [15:0]   exp_cnt;
    logic [AW-1:0] req_a [4];

    // Read data appears one cycle after mem_en is sampled; junk otherwise.
    always @(posedge CLK) begin
        if (bus.mem_en) bus.mem_rdata <= ram[bus.mem_addr];
        else            bus.mem_rdata <= $urandom();
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_mask(input logic [DW-1:0] m, input logic [AW-1:0] a [4]);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ((ram[a[i]] & m) != '0);
        return r;
    endfunction

    task automatic do_check(input logic [DW-1:0] g1, input logic [DW-1:0] g2,
                            input logic [AW-1:0] a [4], input int hold, input bit clr);
        logic [3:0] em;
        logic       em_hit;
        int         waited;
        waited = 0;
        while (bus.chk_ready !== 1'b1 && waited < 20) begin
            @(posedge CLK); #1;
            waited++;
        end
        check_eq("chk_ready_idle", bus.chk_ready, 1);
        em     = ref_mask(g1 | g2, a);
        em_hit = |em;

        @(negedge CLK);
        bus.activeGrid1 = g1;
        bus.activeGrid2 = g2;
        bus.activeAddr1 = a[0];
        bus.activeAddr2 = a[1];
        bus.activeAddr3 = a[2];
        bus.activeAddr4 = a[3];
        bus.chk_valid   = 1'b1;
        bus.res_ready   = 1'b0;
        @(posedge CLK); #1;
        bus.chk_valid   = 1'b0;
        bus.activeGrid1 = $urandom();
        bus.activeGrid2 = $urandom();
        bus.activeAddr1 = AW'($urandom());
        bus.activeAddr2 = AW'($urandom());
        bus.activeAddr3 = AW'($urandom());
        bus.activeAddr4 = AW'($urandom());

        for (int k = 0; k < 4; k++) begin
            check_eq("rd_en", bus.mem_en, 1);
            check_eq("rd_addr", bus.mem_addr, a[k]);
            check_eq("valid_early", bus.res_valid, 0);
            @(posedge CLK); #1;
        end
        check_eq("rd_en_off", bus.mem_en, 0);
        check_eq("valid_early", bus.res_valid, 0);
        @(posedge CLK); #1;
        check_eq("res_valid", bus.res_valid, 1);
        check_eq("res_hitMask", bus.res_hitMask, em);
        check_eq("res_hit", bus.res_hit, em_hit);
        check_eq("chk_ready_busy", bus.chk_ready, 0);

        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            bus.chk_valid = (h == hold / 2);
            @(posedge CLK); #1;
            check_eq("hold_valid", bus.res_valid, 1);
            check_eq("hold_mask", bus.res_hitMask, em);
            check_eq("hold_hit", bus.res_hit, em_hit);
            check_eq("hold_ready", bus.chk_ready, 0);
            check_eq("hold_rd_en", bus.mem_en, 0);
        end

        @(negedge CLK);
        bus.chk_valid = 1'b0;
        bus.res_ready = 1'b1;
        bus.clr_cnt   = clr;
        @(posedge CLK); #1;
        if (clr) exp_cnt = '0;
        else if (em_hit && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        check_eq("hs_valid", bus.res_valid, 0);
        check_eq("hs_ready", bus.chk_ready, 1);
        check_eq("hs_rd_en", bus.mem_en, 0);
        check_eq("hit_cnt", bus.hit_cnt, exp_cnt);
        @(negedge CLK);
        bus.res_ready = 1'b0;
        bus.clr_cnt   = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        RST_n           = 1'b0;
        bus.chk_valid   = 1'b0;
        bus.res_ready   = 1'b0;
        bus.clr_cnt     = 1'b0;
        bus.activeGrid1 = '0;
        bus.activeGrid2 = '0;
        bus.activeAddr1 = '0;
        bus.activeAddr2 = '0;
        bus.activeAddr3 = '0;
        bus.activeAddr4 = '0;
        exp_cnt         = '0;
        for (int i = 0; i < 2**AW; i++) ram[i] = '0;

        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_chk_ready", bus.chk_ready, 1);
        check_eq("rst_mem_en", bus.mem_en, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_res_hit", bus.res_hit, 0);
        check_eq("rst_hitMask", bus.res_hitMask, 0);
        check_eq("rst_hit_cnt", bus.hit_cnt, 0);
        @(negedge CLK);
        RST_n = 1'b1;

        // All-zero RAM, then a single hit on the third word, then address wrap.
        req_a = '{11'h000, 11'h001, 11'h040, 11'h041};
        do_check(32'h4, 32'h5, req_a, 0, 1'b0);
        ram[11'h040] = 32'h4;
        do_check(32'h4, 32'h5, req_a, 2, 1'b0);
        ram[11'h040] = '0;
        ram[11'h000] = 32'h1;
        req_a = '{11'h7FF, 11'h000, 11'h100, 11'h101};
        do_check(32'h1, 32'h0, req_a, 10, 1'b0);

        for (int i = 0; i < 2**AW; i++) ram[i] = $urandom() & $urandom() & $urandom();
        for (int t = 0; t < 40; t++) begin
            logic [DW-1:0] g1, g2;
            g1 = ($urandom_range(0, 5) == 0) ? '0 : (32'h1 << $urandom_range(0, 31));
            g2 = ($urandom_range(0, 2) == 0) ? '0 : ($urandom() & $urandom());
            for (int k = 0; k < 4; k++) req_a[k] = AW'($urandom());
            do_check(g1, g2, req_a, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        // Counter saturation and clear-versus-increment priority.
        ram[11'h040] = 32'h4;
        req_a = '{11'h000, 11'h001, 11'h040, 11'h041};
        @(negedge CLK);
        force dut.r_hit_cnt = 16'hFFFE;
        @(negedge CLK);
        release dut.r_hit_cnt;
        exp_cnt = 16'hFFFE;
        do_check(32'h4, 32'h0, req_a, 0, 1'b0);
        do_check(32'h4, 32'h0, req_a, 1, 1'b0);
        do_check(32'h4, 32'h0, req_a, 0, 1'b0);
        do_check(32'h4, 32'h0, req_a, 0, 1'b1);
        do_check(32'h4, 32'h0, req_a, 0, 1'b0);

        // Reset three edges into a check discards it.
        @(negedge CLK);
        bus.activeGrid1 = 32'h4;
        bus.activeGrid2 = 32'h0;
        bus.activeAddr1 = 11'h040;
        bus.activeAddr2 = 11'h040;
        bus.activeAddr3 = 11'h040;
        bus.activeAddr4 = 11'h040;
        bus.chk_valid   = 1'b1;
        bus.res_ready   = 1'b1;
        @(posedge CLK); #1;
        bus.chk_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_n = 1'b0;
        #1;
        exp_cnt = '0;
        check_eq("mid_rst_mem_en", bus.mem_en, 0);
        check_eq("mid_rst_ready", bus.chk_ready, 1);
        check_eq("mid_rst_valid", bus.res_valid, 0);
        check_eq("mid_rst_mask", bus.res_hitMask, 0);
        check_eq("mid_rst_cnt", bus.hit_cnt, exp_cnt);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (bus.res_valid === 1'b1 || bus.mem_en === 1'b1) seen++;
        end
        check_eq("post_rst_quiet", seen, 0);
        check_eq("post_rst_cnt", bus.hit_cnt, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/grid_collision_check.md
GRID_COLLISION_CHECK -- requirements
Module: grid_collision_check

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the grid word address width, equal to {massZ,massY}.
REQ-002 Parameter DATA_W, default 32, SHALL set the grid word width, one bit per massX cell.
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RST_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 chk_valid  input  1  SHALL flag that a check request is present.
REQ-006 chk_ready  output  1  SHALL flag that the block accepts a request.
REQ-007 activeGrid1, activeGrid2  input  DATA_W each  SHALL carry the X-cell masks from the upstream grid-activation stage.
REQ-008 activeAddr1..activeAddr4  input  ADDR_W each  SHALL carry the four Z/Y neighbour word addresses from the upstream stage.
REQ-009 mem_en  output  1  SHALL be the grid RAM read enable.
REQ-010 mem_addr  output  ADDR_W  SHALL be the grid RAM read address.
REQ-011 mem_rdata  input  DATA_W  SHALL return RAM data one cycle after the edge that sampled mem_en=1.
REQ-012 res_valid  output  1  SHALL flag that a result is present.
REQ-013 res_ready  input  1  SHALL flag that downstream accepts the result.
REQ-014 res_hit  output  1  SHALL be the OR of res_hitMask.
REQ-015 res_hitMask  output  4  SHALL hold per-word hit flags; bit i corresponds to activeAddr(i+1).
REQ-016 clr_cnt  input  1  SHALL synchronously clear hit_cnt.
REQ-017 hit_cnt  output  16  SHALL count accepted results with res_hit=1.

Function
REQ-018 The block SHALL use the states IDLE, READ, DRAIN and DONE.
REQ-019 chk_ready SHALL be 1 only in IDLE; a request SHALL be accepted at edge N when chk_valid=1 and chk_ready=1, with IDLE->READ at that edge.
REQ-020 At acceptance, the block SHALL latch mask = activeGrid1 | activeGrid2 and all four addresses; later input changes SHALL have no effect on the check in flight.
REQ-021 In READ, mem_en SHALL be 1 with mem_addr = activeAddr1, 2, 3, 4 during the cycles following edges N, N+1, N+2 and N+3 respectively; at edge N+4 the state SHALL change READ->DRAIN.
REQ-022 mem_en SHALL be 0 in IDLE, DRAIN and DONE, and mem_addr SHALL hold its last value there.
REQ-023 Word i SHALL be captured at edge N+2+i, setting hitMask[i] = |(mem_rdata & mask).
REQ-024 At edge N+5 the state SHALL change DRAIN->DONE, and res_valid SHALL rise with all four hitMask bits final; fixed latency SHALL be 5 edges.
REQ-025 In DONE, res_valid, res_hit and res_hitMask SHALL hold stable until an edge with res_ready=1, which SHALL move the state DONE->IDLE and clear res_valid.
REQ-026 A new request SHALL not be accepted at the handshake edge; minimum request spacing SHALL be 7 cycles.
REQ-027 Address arithmetic from upstream wraps modulo 2^ADDR_W; the block SHALL read the given address without range checks.
REQ-028 A mask of 0 SHALL yield res_hitMask=0 regardless of RAM data.
REQ-029 hit_cnt SHALL increment by 1 at each result handshake with res_hit=1 and saturate at 0xFFFF.
REQ-030 When clr_cnt=1 and an increment occur at the same edge, clear SHALL win, giving hit_cnt=0.

Reset
REQ-031 RST_n=0 SHALL immediately force state IDLE, chk_ready=1, mem_en=0, mem_addr=0, res_valid=0, res_hit=0, res_hitMask=0 and hit_cnt=0.
REQ-032 Reset during READ, DRAIN or DONE SHALL discard the in-flight check with no result emitted; RAM data returning after reset SHALL be ignored.

Verification
REQ-033 RAM all-zero, grid1=0x4, grid2=0x5, addrs 0x000/0x001/0x040/0x041, res_ready=1 -> mem_addr sequence 000,001,040,041; res_valid at N+5; hitMask=0000; hit=0; hit_cnt=0.
REQ-034 RAM[0x040]=0x00000004, other words 0, same request -> hitMask=0100; hit=1; hit_cnt=1.
REQ-035 addr1=0x7FF, addr2=0x000 (wrap), RAM[0x000]=0x1, mask 0x1 -> hitMask=0010; one read at 0x7FF and one at 0x000.
REQ-036 Hold res_ready=0 for 10 cycles -> outputs stable; chk_ready=0; a chk_valid pulse is ignored; after res_ready=1, chk_ready returns one cycle later.
REQ-037 Assert RST_n=0 at edge N+3 -> mem_en=0 immediately; no res_valid ever occurs; hit_cnt=0.
REQ-038 Preload hit_cnt=0xFFFF via 65535 hits, then another hit -> stays 0xFFFF; clr_cnt coincident with a hit -> 0.
